if_id_stage: RTL and testbench

Instruction-fetch and IF/ID pipeline register stage of the five-stage RISC-V core. Takes the current fetch address from the PC counter, issues one request at a time to instruction memory, and captures the returned word into the IF/ID register for decode. Handles variable memory latency, decode stalls through a one-entry skid buffer, and branch flushes, including dropping stale in-flight responses. Pulses `pc_advance` back to the PC source each time an instruction is handed to decode.

---
 rtl/core_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 57 +++++
 rtl/if_id_stage.sv | 163 ++++++++++++++++
 tb/tb_if_id_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the five-stage RISC-V core
//               front end: XLEN, reset PC, canonical NOP and the fetch FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0100_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        ISSUE = 2'd0,   // drive a request this cycle
        WAIT  = 2'd1,   // one request outstanding
        HELD  = 2'd2    // response parked in the skid buffer
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {pc, inst} holding register used when a fetch
//               response returns while decode is stalled.
// Ports       : clock, reset   - clock / synchronous active-high reset
//               load_i         - capture pc_i/inst_i, become full
//               drain_i        - entry consumed, become empty
//               clear_i        - discard entry (flush)
//               pc_i, inst_i   - entry to capture
//               full_o         - entry valid
//               pc_o, inst_o   - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            full_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            full_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    // Payload is only meaningful while full, so it needs no reset.
    always_ff @(posedge clock) begin
        if (load_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Instruction fetch plus IF/ID pipeline register. Issues one
//               imem request at a time, tolerates any response latency >= 1,
//               parks a response in a skid buffer while decode stalls, and
//               squashes the slot and any in-flight fetch on flush.
// Ports       : clock, reset          - clock / synchronous active-high reset
//               pc_in                 - current fetch PC
//               stall, flush          - hazard hold / branch redirect
//               imem_req, imem_addr   - request strobe and address
//               imem_rvalid/rdata     - response
//               pc_advance            - instruction handed to decode this cycle
//               id_valid/id_pc/id_inst- IF/ID slot
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            pc_advance,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;

    logic            skid_load, skid_drain, skid_clear, skid_full;
    logic [XLEN-1:0] skid_pc, skid_inst;
    logic            slot_free;

    assign slot_free = !id_valid_q || !stall;

    fetch_skid_buf u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (fetch_pc_q),
        .inst_i  (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        imem_req   = 1'b0;
        pc_advance = 1'b0;

        if (reset) begin
            state_d    = ISSUE;
            // A response owed to a request cut off by reset may still land
            // after release; remember to throw it away. Once in ISSUE the
            // flag simply holds for the remainder of a long reset.
            drop_d     = drop_q || (state_q == WAIT);
            id_valid_d = 1'b0;
            id_pc_d    = RESET_PC;
            id_inst_d  = NOP_INST;
        end else begin
            case (state_q)
                ISSUE: begin
                    imem_req   = 1'b1;
                    fetch_pc_d = pc_in;
                    state_d    = WAIT;
                    // The request just issued belongs to the squashed path.
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        if (imem_rvalid) begin
                            drop_d  = 1'b0;
                            state_d = ISSUE;
                        end else begin
                            drop_d  = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ISSUE;
                        end else if (slot_free) begin
                            id_valid_d = 1'b1;
                            id_pc_d    = fetch_pc_q;
                            id_inst_d  = imem_rdata;
                            pc_advance = 1'b1;
                            state_d    = ISSUE;
                        end else begin
                            skid_load  = 1'b1;
                            state_d    = HELD;
                        end
                    end
                end
                HELD: begin
                    if (flush) begin
                        skid_clear = 1'b1;
                        state_d    = ISSUE;
                    end else if (!stall && skid_full) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = skid_pc;
                        id_inst_d  = skid_inst;
                        skid_drain = 1'b1;
                        pc_advance = 1'b1;
                        state_d    = ISSUE;
                    end
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase

            // Flush overrides both capture and stall on the slot itself;
            // id_pc is left alone on purpose.
            if (flush) begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clock) begin
        state_q    <= state_d;
        drop_q     <= drop_d;
        fetch_pc_q <= fetch_pc_d;
        id_valid_q <= id_valid_d;
        id_pc_q    <= id_pc_d;
        id_inst_q  <= id_inst_d;
    end

    assign imem_addr = pc_in;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Directed bench for if_id_stage with a transaction-level
//               reference model and hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] pc_in = RST_PC;
    logic [31:0] imem_rdata = 32'h0;

    wire         imem_req;
    wire         pc_advance;
    wire         id_valid;
    wire  [31:0] imem_addr;
    wire  [31:0] id_pc;
    wire  [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    if_id_stage #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_advance  (pc_advance),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks transactions (request in flight, stale
    // response owed, parked response, decode slot) rather than states.
    // ------------------------------------------------------------------
    logic        m_init = 1'b0;
    logic        m_out = 1'b0;
    logic [31:0] m_out_pc = 32'h0;
    logic        m_stale = 1'b0;
    logic        m_park = 1'b0;
    logic [31:0] m_park_pc = 32'h0;
    logic [31:0] m_park_inst = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic        last_adv = 1'b0;

    always @(negedge clock) begin : p_model
        logic e_req;
        logic e_adv;
        logic free;

        if (m_init) begin
            chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
            chk("id_pc", id_pc, m_pc);
            chk("id_inst", id_inst, m_inst);
        end

        e_req = !reset && !m_out && !m_park;
        e_adv = 1'b0;
        free  = !m_valid || !stall;

        if (reset) begin
            m_stale = m_stale | m_out;
            m_out   = 1'b0;
            m_park  = 1'b0;
            m_valid = 1'b0;
            m_pc    = RST_PC;
            m_inst  = NOP;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (m_out) begin
                if (flush) begin
                    if (imem_rvalid) begin
                        m_out   = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    m_out = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else if (free) begin
                        m_valid = 1'b1;
                        m_pc    = m_out_pc;
                        m_inst  = imem_rdata;
                        e_adv   = 1'b1;
                    end else begin
                        m_park      = 1'b1;
                        m_park_pc   = m_out_pc;
                        m_park_inst = imem_rdata;
                    end
                end
            end else if (m_park) begin
                if (flush) begin
                    m_park = 1'b0;
                end else if (!stall) begin
                    m_park  = 1'b0;
                    m_valid = 1'b1;
                    m_pc    = m_park_pc;
                    m_inst  = m_park_inst;
                    e_adv   = 1'b1;
                end
            end else begin
                m_out    = 1'b1;
                m_out_pc = pc_in;
                if (flush) m_stale = 1'b1;
            end
            if (flush) begin
                m_valid = 1'b0;
                m_inst  = NOP;
            end
        end

        if (m_init) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
            chk("pc_advance", {31'b0, pc_advance}, {31'b0, e_adv});
            if (e_req) chk("imem_addr", imem_addr, pc_in);
        end
        last_adv = e_adv;
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge; literal
    // checks sample 1 unit later, well before the falling edge.
    // ------------------------------------------------------------------
    task automatic set_in(input logic r, input logic st, input logic fl,
                          input logic rv, input logic [31:0] rd);
        reset       = r;
        stall       = st;
        flush       = fl;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    // PC counter stand-in: steps on every delivery.
    task automatic tick();
        @(posedge clock);
        #1;
        if (last_adv) pc_in = pc_in + 32'd4;
    endtask

    initial begin
        // Reset
        pc_in = RST_PC;
        repeat (3) begin
            set_in(1, 0, 0, 0, 32'h0);
            chk("req_in_reset", {31'b0, imem_req}, 32'd0);
            tick();
        end
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0100_0000);
        chk("rst_id_inst", id_inst, 32'h0000_0013);

        // k=1 streaming
        set_in(0, 0, 0, 0, 32'h0);
        chk("s1_req", {31'b0, imem_req}, 32'd1);
        chk("s1_addr", imem_addr, 32'h0100_0000);
        tick();
        set_in(0, 0, 0, 1, 32'h0010_0093);
        chk("s1_adv", {31'b0, pc_advance}, 32'd1);
        chk("s1_req_wait", {31'b0, imem_req}, 32'd0);
        tick();
        chk("s1_id_pc", id_pc, 32'h0100_0000);
        chk("s1_id_inst", id_inst, 32'h0010_0093);
        set_in(0, 0, 0, 0, 32'h0);
        chk("s2_addr", imem_addr, 32'h0100_0004);
        tick();
        set_in(0, 0, 0, 1, 32'h0020_0113);
        tick();
        chk("s2_id_pc", id_pc, 32'h0100_0004);

        // Response while stalled -> skid, then release
        set_in(0, 1, 0, 0, 32'h0);
        tick();
        set_in(0, 1, 0, 1, 32'h0050_0093);
        chk("stall_noadv", {31'b0, pc_advance}, 32'd0);
        tick();
        chk("stall_frozen_inst", id_inst, 32'h0020_0113);
        chk("stall_frozen_pc", id_pc, 32'h0100_0004);
        set_in(0, 1, 0, 0, 32'h0);
        chk("held_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        chk("held_adv", {31'b0, pc_advance}, 32'd1);
        tick();
        chk("drain_inst", id_inst, 32'h0050_0093);
        chk("drain_pc", id_pc, 32'h0100_0008);

        // Flush in WAIT, stale response 3 cycles later
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 1, 0, 32'h0);
        tick();
        chk("fl_valid", {31'b0, id_valid}, 32'd0);
        chk("fl_inst", id_inst, 32'h0000_0013);
        chk("fl_pc_kept", id_pc, 32'h0100_0008);
        pc_in = 32'h0200_0000;
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("stale_noadv", {31'b0, pc_advance}, 32'd0);
        tick();
        chk("stale_valid", {31'b0, id_valid}, 32'd0);
        chk("stale_inst", id_inst, 32'h0000_0013);
        set_in(0, 0, 0, 0, 32'h0);
        chk("redir_req", {31'b0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h0200_0000);
        tick();
        set_in(0, 0, 0, 1, 32'h00A0_0513);
        tick();

        // Flush and response together while stalled
        set_in(0, 1, 0, 0, 32'h0);
        tick();
        set_in(0, 1, 1, 1, 32'h1111_1111);
        chk("flrv_noadv", {31'b0, pc_advance}, 32'd0);
        tick();
        chk("flrv_valid", {31'b0, id_valid}, 32'd0);
        chk("flrv_pc", id_pc, 32'h0200_0000);
        pc_in = 32'h0300_0000;
        set_in(0, 0, 0, 0, 32'h0);
        chk("flrv_issue", {31'b0, imem_req}, 32'd1);
        tick();
        set_in(0, 0, 0, 1, 32'h0030_0193);
        chk("flrv_next_adv", {31'b0, pc_advance}, 32'd1);
        tick();
        chk("flrv_next_inst", id_inst, 32'h0030_0193);

        // Flush while HELD
        set_in(0, 1, 0, 0, 32'h0);
        tick();
        set_in(0, 1, 0, 1, 32'h0BAD_C0DE);
        tick();
        set_in(0, 1, 1, 0, 32'h0);
        tick();
        chk("flheld_valid", {31'b0, id_valid}, 32'd0);
        pc_in = 32'h0400_0000;
        set_in(0, 0, 0, 0, 32'h0);
        chk("flheld_issue", {31'b0, imem_req}, 32'd1);
        tick();
        set_in(0, 0, 0, 1, 32'h0040_0213);
        tick();
        chk("flheld_inst", id_inst, 32'h0040_0213);
        chk("flheld_pc", id_pc, 32'h0400_0000);

        // Reset during WAIT, late response after release
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        pc_in = RST_PC;
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 1, 32'hBAD0_BAD0);
        chk("late_noadv", {31'b0, pc_advance}, 32'd0);
        tick();
        chk("late_valid", {31'b0, id_valid}, 32'd0);
        chk("late_pc", id_pc, 32'h0100_0000);
        // Fresh fetch at k=2
        set_in(0, 0, 0, 0, 32'h0);
        chk("late_reissue", imem_addr, 32'h0100_0000);
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 0, 1, 32'h0000_0513);
        tick();
        chk("k2_valid", {31'b0, id_valid}, 32'd1);
        chk("k2_inst", id_inst, 32'h0000_0513);
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
